// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Branch/jump resolution stage. Registers a decoded control-flow
//            op, forms its target, evaluates the condition, issues a
//            one-cycle PC redirect to fetch and squashes the wrong-path
//            slots that follow it. Also counts issued redirects.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      br_offset_sl2,
    input  logic [25:0]      jump_index,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt
);

    // Op encodings
    localparam logic [2:0] c_OP_NONE = 3'b000;
    localparam logic [2:0] c_OP_BEQ  = 3'b001;
    localparam logic [2:0] c_OP_BNE  = 3'b010;
    localparam logic [2:0] c_OP_BLEZ = 3'b011;
    localparam logic [2:0] c_OP_BGTZ = 3'b100;
    localparam logic [2:0] c_OP_J    = 3'b101;

    // Squash FSM encoding
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_SQUASH = 1'b1;

    // Squash counter sizing; a depth of 1 only drops the redirect-edge slot,
    // which the S1 load gating already handles, so the FSM never leaves IDLE.
    localparam int                 c_CNT_BITS   = $clog2(FLUSH_DEPTH) + 1;
    localparam logic [c_CNT_BITS-1:0] c_CNT_INIT = c_CNT_BITS'(FLUSH_DEPTH - 1);
    localparam logic [c_CNT_BITS-1:0] c_CNT_ONE  = c_CNT_BITS'(1);
    localparam logic               c_USE_SQUASH = (FLUSH_DEPTH > 1);
    localparam logic [CNT_W-1:0]   c_TAKEN_INC  = CNT_W'(1);

    // S1 pipeline register contents
    logic        r_s1_valid;
    logic [2:0]  r_s1_op;
    logic [31:0] r_s1_pc_plus4;
    logic [31:0] r_s1_off;
    logic [25:0] r_s1_jidx;
    logic [31:0] r_s1_rs;
    logic [31:0] r_s1_rt;

    // Squash FSM
    logic [0:0]            r_state;
    logic [c_CNT_BITS-1:0] r_sq_cnt;
    logic [0:0]            w_state_nxt;
    logic [c_CNT_BITS-1:0] w_sq_cnt_nxt;

    // Resolution datapath
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_tgt;
    logic        w_cond;
    logic        w_taken_now;
    logic        w_squash_in;

    // Capture the incoming op into S1 unless held by a hazard stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_op       <= c_OP_NONE;
            r_s1_pc_plus4 <= 32'd0;
            r_s1_off      <= 32'd0;
            r_s1_jidx     <= 26'd0;
            r_s1_rs       <= 32'd0;
            r_s1_rt       <= 32'd0;
        end else if (!stall) begin
            r_s1_valid    <= in_valid & ~w_squash_in;
            r_s1_op       <= op;
            r_s1_pc_plus4 <= pc_plus4;
            r_s1_off      <= br_offset_sl2;
            r_s1_jidx     <= jump_index;
            r_s1_rs       <= rs_val;
            r_s1_rt       <= rt_val;
        end
    end

    // Target formation: PC-relative branch (modulo 2^32) and region jump
    assign w_br_tgt = r_s1_pc_plus4 + r_s1_off;
    assign w_j_tgt  = {r_s1_pc_plus4[31:28], r_s1_jidx, 2'b00};
    assign w_tgt    = (r_s1_op == c_OP_J) ? w_j_tgt : w_br_tgt;

    // Condition evaluation; NONE and reserved encodings are never taken
    always_comb begin
        w_cond = 1'b0;
        case (r_s1_op)
            c_OP_NONE: w_cond = 1'b0;
            c_OP_BEQ:  w_cond = (r_s1_rs == r_s1_rt);
            c_OP_BNE:  w_cond = (r_s1_rs != r_s1_rt);
            c_OP_BLEZ: w_cond = r_s1_rs[31] | (r_s1_rs == 32'd0);
            c_OP_BGTZ: w_cond = ~r_s1_rs[31] & (r_s1_rs != 32'd0);
            c_OP_J:    w_cond = 1'b1;
            default:   w_cond = 1'b0;
        endcase
    end

    // A stalled S1 must not resolve, otherwise the held op would fire twice
    assign w_taken_now = r_s1_valid & w_cond & ~stall;
    assign w_squash_in = w_taken_now | (r_state == c_SQUASH);

    // Redirect pulse, target and taken counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            taken_cnt   <= '0;
        end else begin
            redirect <= w_taken_now;
            if (w_taken_now) begin
                redirect_pc <= w_tgt;
                taken_cnt   <= taken_cnt + c_TAKEN_INC;
            end
        end
    end

    // Squash FSM next-state: count remaining wrong-path slots after a redirect
    always_comb begin
        w_state_nxt  = r_state;
        w_sq_cnt_nxt = r_sq_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_taken_now && c_USE_SQUASH) begin
                    w_state_nxt  = c_SQUASH;
                    w_sq_cnt_nxt = c_CNT_INIT;
                end
            end
            c_SQUASH: begin
                if (!stall) begin
                    if (r_sq_cnt == c_CNT_ONE) begin
                        w_state_nxt  = c_IDLE;
                        w_sq_cnt_nxt = '0;
                    end else begin
                        w_sq_cnt_nxt = r_sq_cnt - c_CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt  = c_IDLE;
                w_sq_cnt_nxt = '0;
            end
        endcase
    end

    // Squash FSM state, counter and registered flush indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_sq_cnt <= '0;
            flush    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sq_cnt <= w_sq_cnt_nxt;
            flush    <= (w_state_nxt == c_SQUASH);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Self-checking bench for branch_resolve_unit. Directed vectors
//            push expected redirects into a queue; a monitor pops and
//            compares each redirect pulse the DUT presents.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int CNT_W = 16;

    localparam logic [2:0] c_NONE = 3'b000;
    localparam logic [2:0] c_BEQ  = 3'b001;
    localparam logic [2:0] c_BNE  = 3'b010;
    localparam logic [2:0] c_BLEZ = 3'b011;
    localparam logic [2:0] c_BGTZ = 3'b100;
    localparam logic [2:0] c_J    = 3'b101;

    typedef struct packed {
        logic [31:0]      pc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             stall;
    logic [2:0]       op;
    logic [31:0]      pc_plus4;
    logic [31:0]      br_offset_sl2;
    logic [25:0]      jump_index;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] taken_cnt;

    int               checks;
    int               errors;
    exp_t             exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    logic             prev_redirect;

    branch_resolve_unit #(
        .FLUSH_DEPTH(2),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .stall        (stall),
        .op           (op),
        .pc_plus4     (pc_plus4),
        .br_offset_sl2(br_offset_sl2),
        .jump_index   (jump_index),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .taken_cnt    (taken_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] pc, input logic [31:0] off,
                         input logic [25:0] ji, input logic [31:0] rs, input logic [31:0] rt);
        in_valid      = 1'b1;
        op            = o;
        pc_plus4      = pc;
        br_offset_sl2 = off;
        jump_index    = ji;
        rs_val        = rs;
        rt_val        = rt;
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        op       = c_NONE;
    endtask

    task automatic expect_redirect(input logic [31:0] pc);
        exp_cnt = exp_cnt + 1'b1;
        exp_q.push_back('{pc: pc, cnt: exp_cnt});
    endtask

    // Monitor: every redirect pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_redirect <= 1'b0;
        end else begin
            prev_redirect <= redirect;
            if (redirect) begin
                checks++;
                if (prev_redirect) begin
                    errors++;
                    $display("FAIL pulse_width: got redirect high 2 cycles required 1");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_redirect: got pc %h cnt %0d required no redirect",
                             redirect_pc, taken_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (redirect_pc !== e.pc || taken_cnt !== e.cnt) begin
                        errors++;
                        $display("FAIL redirect: got pc %h cnt %0d required pc %h cnt %0d",
                                 redirect_pc, taken_cnt, e.pc, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        exp_cnt       = '0;
        prev_redirect = 1'b0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        in_valid      = 1'b0;
        op            = c_NONE;
        pc_plus4      = 32'd0;
        br_offset_sl2 = 32'd0;
        jump_index    = 26'd0;
        rs_val        = 32'd0;
        rt_val        = 32'd0;

        // Reset state
        step();
        step();
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // BEQ taken: 0x0040_0010 + 0x20
        drive(c_BEQ, 32'h0040_0010, 32'h0000_0020, 26'd0, 32'd5, 32'd5);
        expect_redirect(32'h0040_0030);
        step();
        bubble();
        step();
        chk("beq_redirect", {31'd0, redirect}, 32'd1);
        chk("beq_flush", {31'd0, flush}, 32'd1);
        chk("beq_cnt", {16'd0, taken_cnt}, 32'd1);
        step();
        chk("beq_redirect_end", {31'd0, redirect}, 32'd0);
        chk("beq_flush_end", {31'd0, flush}, 32'd0);
        step();

        // Not-taken cases back to back
        drive(c_BNE, 32'h0000_1000, 32'h0000_0100, 26'd0, 32'd7, 32'd7);
        step();
        drive(c_BLEZ, 32'h0000_1004, 32'h0000_0100, 26'd0, 32'd1, 32'd0);
        step();
        drive(c_BGTZ, 32'h0000_1008, 32'h0000_0100, 26'd0, 32'h8000_0000, 32'd0);
        step();
        bubble();
        chk("nt_flush_a", {31'd0, flush}, 32'd0);
        step();
        chk("nt_flush_b", {31'd0, flush}, 32'd0);
        step();
        chk("nt_cnt", {16'd0, taken_cnt}, 32'd1);

        // BGTZ with target wrap, then J
        drive(c_BGTZ, 32'h0000_0004, 32'hFFFF_FFF0, 26'd0, 32'd3, 32'd0);
        expect_redirect(32'hFFFF_FFF4);
        step();
        bubble();
        step();
        step();
        step();
        drive(c_J, 32'hA000_0000, 32'd0, 26'h100, 32'd0, 32'd0);
        expect_redirect(32'hA000_0400);
        step();
        bubble();
        step();
        chk("j_pc", redirect_pc, 32'hA000_0400);
        step();
        step();

        // BEQ, BEQ (squashed), bubble (squashed), then BNE taken
        drive(c_BEQ, 32'h0000_2000, 32'h0000_0040, 26'd0, 32'd9, 32'd9);
        expect_redirect(32'h0000_2040);
        step();
        drive(c_BEQ, 32'h0000_2004, 32'h0000_0080, 26'd0, 32'd1, 32'd1);
        step();
        bubble();
        step();
        drive(c_BNE, 32'h0000_3000, 32'h0000_0010, 26'd0, 32'd1, 32'd2);
        expect_redirect(32'h0000_3010);
        step();
        bubble();
        step();
        chk("b2b_cnt", {16'd0, taken_cnt}, 32'd5);
        step();
        step();

        // Stall during SQUASH holds flush; a taken op presented meanwhile is dropped
        drive(c_BEQ, 32'h0000_4000, 32'h0000_0100, 26'd0, 32'd3, 32'd3);
        expect_redirect(32'h0000_4100);
        step();
        bubble();
        step();
        chk("stall_flush_0", {31'd0, flush}, 32'd1);
        stall = 1'b1;
        drive(c_BEQ, 32'h0000_5000, 32'h0000_0100, 26'd0, 32'd4, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_flush_held", {31'd0, flush}, 32'd1);
        end
        stall = 1'b0;
        step();
        bubble();
        chk("stall_flush_done", {31'd0, flush}, 32'd0);
        step();
        chk("stall_no_redirect", {31'd0, redirect}, 32'd0);
        step();

        // Async reset in the middle of SQUASH
        drive(c_J, 32'h1000_0000, 32'd0, 26'h3, 32'd0, 32'd0);
        expect_redirect(32'h1000_000C);
        step();
        bubble();
        step();
        chk("sq_flush_before_rst", {31'd0, flush}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_redirect", {31'd0, redirect}, 32'd0);
        chk("arst_pc", redirect_pc, 32'd0);
        chk("arst_cnt", {16'd0, taken_cnt}, 32'd0);
        exp_cnt = '0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("post_rst_flush", {31'd0, flush}, 32'd0);

        // First redirect after reset counts from zero again
        drive(c_BLEZ, 32'h0000_0100, 32'h0000_0008, 26'd0, 32'hFFFF_FFFF, 32'd0);
        expect_redirect(32'h0000_0108);
        step();
        bubble();
        for (int i = 0; i < 6; i++) step();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
